// File: rtl/cnn_row_streamer.sv
// cnn_row_streamer: buffers one CNN feature-map row and serializes it
// onto a stalled 32-bit word stream, pixel-major / channel-minor.
//
// Ports:
//   clock_i            rising-edge clock
//   reset_i            synchronous active-high reset
//   row_i              row to send [WIDTH][CHANNELS] x VALUE_BITS
//   row_valid_i        row_i is valid
//   row_accept_o       row captured this cycle when row_valid_i is high
//   out_data_o         stream word (value zero-extended, or header)
//   out_valid_o        out_data_o is valid
//   out_last_o         final data word of the row
//   downstream_stall_i sink not ready; current word is held
//
// Optional feature macro: CNN_ROW_HEADER_EN
//   Precedes each row with a header word {8'hC0, CHANNELS[7:0], row_cnt}.

module cnn_row_streamer #(
  parameter int WIDTH      = 28,
  parameter int CHANNELS   = 2,
  parameter int VALUE_BITS = 8,
  parameter int OUT_BITS   = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [VALUE_BITS-1:0] row_i [WIDTH][CHANNELS],
  input  logic                  row_valid_i,
  output logic                  row_accept_o,
  output logic [OUT_BITS-1:0]   out_data_o,
  output logic                  out_valid_o,
  output logic                  out_last_o,
  input  logic                  downstream_stall_i
);

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [PW-1:0] PIX_LAST = PW'(WIDTH - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);

`ifdef CNN_ROW_HEADER_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_SEND
  } state_e;
  localparam state_e S_FIRST = S_HDR;
`else
  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_e;
  localparam state_e S_FIRST = S_SEND;
`endif

  state_e                state_q;
  state_e                state_d;
  logic [PW-1:0]         pix_q;
  logic [PW-1:0]         pix_d;
  logic [CW-1:0]         ch_q;
  logic [CW-1:0]         ch_d;
  logic [VALUE_BITS-1:0] buf_q [WIDTH][CHANNELS];

  logic load;
  logic last_word;
  logic out_xfer;
  logic in_xfer;

`ifdef CNN_ROW_HEADER_EN
  logic [15:0] rowcnt_q;
  logic [15:0] rowcnt_d;
`endif

  assign last_word = (state_q == S_SEND)
                  && (pix_q == PIX_LAST)
                  && (ch_q == CH_LAST);

  assign out_valid_o = (state_q != S_IDLE);
  assign out_last_o  = last_word;

  // A new row may enter in the same cycle the old row's last
  // word leaves, which keeps back-to-back rows bubble-free.
  assign row_accept_o = !reset_i
                     && ((state_q == S_IDLE)
                      || (last_word && !downstream_stall_i));

  assign out_xfer = out_valid_o && !downstream_stall_i;
  assign in_xfer  = row_valid_i && row_accept_o;

  always_comb begin
    out_data_o = '0;
    if (state_q == S_SEND) begin
      out_data_o = OUT_BITS'(buf_q[pix_q][ch_q]);
    end
`ifdef CNN_ROW_HEADER_EN
    if (state_q == S_HDR) begin
      out_data_o = OUT_BITS'({8'hC0, 8'(CHANNELS), rowcnt_q});
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    ch_d    = ch_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_xfer) begin
          load    = 1'b1;
          state_d = S_FIRST;
          pix_d   = '0;
          ch_d    = '0;
        end
      end
`ifdef CNN_ROW_HEADER_EN
      S_HDR: begin
        if (out_xfer) begin
          state_d = S_SEND;
        end
      end
`endif
      S_SEND: begin
        if (out_xfer) begin
          if (last_word) begin
            pix_d = '0;
            ch_d  = '0;
            if (in_xfer) begin
              load    = 1'b1;
              state_d = S_FIRST;
            end else begin
              state_d = S_IDLE;
            end
          end else if (ch_q == CH_LAST) begin
            ch_d  = '0;
            pix_d = pix_q + 1'b1;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      ch_q    <= ch_d;
    end
  end

  // Row storage needs no reset: it is only read in SEND,
  // which is reachable only after a load.
  always_ff @(posedge clock_i) begin
    if (load) begin
      buf_q <= row_i;
    end
  end

`ifdef CNN_ROW_HEADER_EN
  always_comb begin
    rowcnt_d = rowcnt_q;
    if ((state_q == S_HDR) && out_xfer) begin
      rowcnt_d = rowcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rowcnt_q <= '0;
    end else begin
      rowcnt_q <= rowcnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_cnn_row_streamer.sv
// tb_cnn_row_streamer: random traffic against a word-queue model
// of the row streamer (WIDTH=4, CHANNELS=2).

module tb_cnn_row_streamer;

  localparam int W  = 4;
  localparam int C  = 2;
  localparam int VB = 8;
  localparam int OB = 32;
  localparam int NCYC = 1500;

  typedef struct {
    logic [31:0] d;
    bit          last;
  } word_t;

  logic          clk;
  logic          reset_i;
  logic [VB-1:0] row_i [W][C];
  logic          row_valid_i;
  logic          row_accept_o;
  logic [OB-1:0] out_data_o;
  logic          out_valid_o;
  logic          out_last_o;
  logic          downstream_stall_i;

  cnn_row_streamer #(
    .WIDTH(W),
    .CHANNELS(C),
    .VALUE_BITS(VB),
    .OUT_BITS(OB)
  ) dut (
    .clock_i(clk),
    .reset_i(reset_i),
    .row_i(row_i),
    .row_valid_i(row_valid_i),
    .row_accept_o(row_accept_o),
    .out_data_o(out_data_o),
    .out_valid_o(out_valid_o),
    .out_last_o(out_last_o),
    .downstream_stall_i(downstream_stall_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Model: queue of words still owed to the sink.
  word_t         exp_q[$];
  int            rows_since_rst = 0;
  bit            armed = 0;
  bit            in_x  = 0;
  bit            out_x = 0;
  bit            rst_x = 0;
  logic [VB-1:0] cap_row [W][C];

  always @(negedge clk) begin
    int  n;
    bit  acc;
    n   = exp_q.size();
    acc = !reset_i && (n == 0 || (n == 1 && !downstream_stall_i));
    if (armed) begin
      chk("accept", 32'(row_accept_o), 32'(acc));
      chk("valid", 32'(out_valid_o), 32'(n != 0));
      if (n != 0) begin
        chk("data", out_data_o, exp_q[0].d);
        chk("last", 32'(out_last_o), 32'(exp_q[0].last));
      end else begin
        chk("idle_data", out_data_o, 32'h0);
        chk("idle_last", 32'(out_last_o), 32'h0);
      end
    end
    in_x    = row_valid_i && acc;
    out_x   = (n != 0) && !downstream_stall_i;
    rst_x   = reset_i;
    cap_row = row_i;
  end

  always @(posedge clk) begin
    word_t w;
    if (rst_x) begin
      exp_q.delete();
      rows_since_rst = 0;
      armed = 1;
    end else begin
      if (out_x) void'(exp_q.pop_front());
      if (in_x) begin
`ifdef CNN_ROW_HEADER_EN
        w.d    = {8'hC0, 8'(C), 16'(rows_since_rst)};
        w.last = 0;
        exp_q.push_back(w);
`endif
        rows_since_rst++;
        for (int p = 0; p < W; p++) begin
          for (int c = 0; c < C; c++) begin
            w.d    = 32'(cap_row[p][c]);
            w.last = (p == W - 1) && (c == C - 1);
            exp_q.push_back(w);
          end
        end
      end
    end
  end

  task automatic rand_row(input int kind);
    for (int p = 0; p < W; p++) begin
      for (int c = 0; c < C; c++) begin
        if (kind == 0) row_i[p][c] = 8'hFF;
        else if (kind == 1) row_i[p][c] = 8'(16 * p + c);
        else row_i[p][c] = 8'($urandom);
      end
    end
  endtask

  initial begin
    reset_i            = 1'b1;
    row_valid_i        = 1'b0;
    downstream_stall_i = 1'b0;
    rand_row(2);
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    rand_row(1);
    row_valid_i = 1'b1;
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      if (k < 12) begin
        if (in_x) row_valid_i = 1'b0;
      end else if (k < 40) begin
        // Back-to-back rows with occasional multi-cycle stalls.
        if (in_x || !row_valid_i) rand_row(k < 25 ? 0 : 1);
        row_valid_i        = 1'b1;
        downstream_stall_i = ((k % 7) < 3);
      end else begin
        reset_i            = ($urandom_range(99) == 0);
        downstream_stall_i = ($urandom_range(9) < 3);
        if (!row_valid_i || in_x) begin
          if ($urandom_range(3) != 0) begin
            row_valid_i = 1'b1;
            rand_row($urandom_range(3));
          end else begin
            row_valid_i = 1'b0;
            rand_row(2);
          end
        end
      end
    end
    reset_i            = 1'b0;
    downstream_stall_i = 1'b0;
    if (!in_x) row_valid_i = row_valid_i;
    @(posedge clk);
    #1;
    row_valid_i = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cnn_row_streamer.md
# cnn_row_streamer

Transmit-side counterpart of the CNN input path. Accepts one complete feature-map row (`WIDTH` pixels × `CHANNELS` values) from a `cnn_layer` row output over a valid/accept handshake. Serializes that row onto the 32-bit word stream that `cnn_top` drives on `out_data`/`out_valid` under `downstream_stall`. Only one row is buffered, so a row can be captured while the stream is idle or in the same cycle the previous row's last word leaves.

## Interface
- `WIDTH`, 28: pixels per row.
- `CHANNELS`, 2: values per pixel.
- `VALUE_BITS`, 8: bits per value; must be ≤ `OUT_BITS`.
- `OUT_BITS`, 32: stream word width.

Ports:
- `clock_i` in 1: single clock, rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `row_i` in `[VALUE_BITS-1:0]` unpacked `[WIDTH][CHANNELS]`: row to send; sampled only on accept.
- `row_valid_i` in 1: `row_i` is valid.
- `row_accept_o` out 1: row captured this cycle if `row_valid_i` is also high.
- `out_data_o` out `OUT_BITS`: stream word.
- `out_valid_o` out 1: `out_data_o` is valid.
- `out_last_o` out 1: current word is the final word of the row.
- `downstream_stall_i` in 1: sink not ready; the word is held.

## Operation
- Transfers:
  - Input transfer: `row_valid_i && row_accept_o` at a rising edge. The full row is copied into an internal buffer `[WIDTH][CHANNELS]`.
  - Output transfer: `out_valid_o && !downstream_stall_i` at a rising edge.
- Word order is pixel-major, channel-minor: (p0,c0), (p0,c1), …, (p0,cC-1), (p1,c0), …, (pW-1,cC-1). That is `WIDTH*CHANNELS` data words per row.
- Data word format: value in bits `[VALUE_BITS-1:0]`; upper bits are zero.
- State machine states: IDLE, HDR (present only with `CNN_ROW_HEADER_EN`), SEND.
  - IDLE → HDR, or IDLE → SEND when the macro is absent, on an input transfer.
  - HDR → SEND on an output transfer of the header word.
  - SEND steps the counters `ch_idx` (0..`CHANNELS`-1, inner) and `pix_idx` (0..`WIDTH`-1, outer) on each output transfer.
  - On the output transfer of the last word (`pix_idx=WIDTH-1`, `ch_idx=CHANNELS-1`):
    - with a simultaneous input transfer → HDR or SEND, counters cleared, new row loaded;
    - otherwise → IDLE.
- `row_accept_o` = `!reset_i && (state==IDLE || (state==SEND && out_last_o && !downstream_stall_i))`. This signal has a combinational dependence on `downstream_stall_i`.
- `out_last_o` is high only on the final data word, never on a header word.
- While stalled, `out_data_o`, `out_valid_o` and `out_last_o` are held unchanged and the counters freeze.
- `row_valid_i` while busy (not accepted) is ignored. The upstream holds its row until accepted.

## Timing
- Reset values: `out_valid_o`=0, `out_data_o`=0, `out_last_o`=0, `row_accept_o`=0 during reset and 1 on the first cycle after it, state=IDLE, counters=0, row counter=0.
- Latency: input transfer at edge N → first word (header or data) has `out_valid_o`=1 after edge N, i.e. visible in cycle N+1.
- Throughput with no stall: one word per cycle. Back-to-back rows have zero bubble cycles.
- `out_valid_o` drops to 0 the cycle after the last-word transfer, unless a new row was accepted on that same edge.
- Reset mid-row: the buffered row is discarded, no further words are sent, and the next row restarts at word 0.
- Stall asserted in the same cycle as the last word: no accept occurs, state stays in SEND, and the word is held.

## Configuration
- `CNN_ROW_HEADER_EN`, when defined:
  - each row is preceded by one header word: bits `[31:24]`=8'hC0, bits `[23:16]`=`CHANNELS`, bits `[15:0]`=row counter;
  - the row counter increments on each header transfer, wraps 16'hFFFF→0, and is cleared by reset;
  - a row is `WIDTH*CHANNELS+1` words.
- When not defined: there is no HDR state, no row counter, and data words only.

## Test plan
All scenarios use `WIDTH`=4, `CHANNELS`=2.
- Basic: reset, then one row with value = 8'h10·p + c, no stall → 8 words 0x00, 0x01, 0x10, 0x11, …, 0x31 on consecutive cycles starting 1 cycle after accept. `out_last_o` is high only with 0x31; `out_valid_o` then drops.
- Stall: assert `downstream_stall_i` for 3 cycles while word 0x10 is presented → 0x10 is held stable for 4 cycles, then the sequence continues; there are no duplicate or dropped words.
- Back-to-back: second row (all 8'hFF) presented during the first row's transfer → `row_accept_o`=0 until the last word transfers. It is then accepted on that edge, and 0xFF words follow with no idle cycle.
- Stall on last word: stall while 0x31 is presented → `row_accept_o`=0 throughout the stall; accept occurs on the edge where the stall deasserts.
- Reset mid-row: assert `reset_i` after 3 words → outputs go to 0 next cycle. A new row then starts from word (p0,c0).
- With `CNN_ROW_HEADER_EN`: two rows → header words 0xC0020000 and 0xC0020001 each precede their 8 data words, and `out_last_o` never accompanies a header.
